// File: rtl/des_pkg.sv
// Shared DES datapath constants and the hold-stage state encoding.
// The permutation and round stages reuse the width constants.
package des_pkg;

  localparam int BLOCK_W         = 64;
  localparam int HALF_W          = 32;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_BLOCK = 8;
  localparam int CNT_W           = 3;
  localparam int PAD_W           = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } hold_state_e;

  // Bytes still missing after the byte at index c closes the block.
  function automatic logic [PAD_W-1:0] padFromCount(input logic [CNT_W-1:0] c);
    return {1'b0, 3'd7 - c};
  endfunction

endpackage

// File: rtl/des_byte_packer.sv
// Fill side of the loader: collects bytes into a block, pads blocks closed
// early by a last byte, and flags the block as full for the hold stage.
module des_byte_packer
  import des_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PAD_BYTE   = 8'h00,
  parameter int                BYTE_COUNT = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [BYTE_W-1:0]  i_din,
  input  logic               i_din_valid,
  input  logic               i_din_last,
  input  logic               i_take,
  output logic               o_din_ready,
  output logic               o_full,
  output logic [BLOCK_W:1]   o_data,
  output logic [PAD_W-1:0]   o_pad,
  output logic               o_last
);

  if (BYTE_COUNT != BYTES_PER_BLOCK) begin : g_bad_byte_count
    $error("des_byte_packer: BYTE_COUNT must be 8");
  end

  logic [BYTE_W-1:0] r_bytes [BYTES_PER_BLOCK];
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic [PAD_W-1:0]  r_pad;
  logic              r_last;
  logic              r_armed;

  logic w_ready;
  logic w_xfer;

  // r_armed keeps DIN_READY low until the first edge after reset releases.
  assign w_ready = r_armed & ~r_full;
  assign w_xfer  = i_din_valid & w_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < BYTES_PER_BLOCK; k++) begin
        r_bytes[k] <= '0;
      end
      r_count <= '0;
      r_full  <= 1'b0;
      r_pad   <= '0;
      r_last  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_xfer) begin
        r_bytes[r_count] <= i_din;
        if (i_din_last) begin
          // Overwrite the tail so stale bytes from the previous block never leak.
          for (int k = 0; k < BYTES_PER_BLOCK; k++) begin
            if (k > int'(r_count)) begin
              r_bytes[k] <= PAD_BYTE;
            end
          end
          r_pad   <= padFromCount(r_count);
          r_last  <= 1'b1;
          r_count <= '0;
          r_full  <= 1'b1;
        end else if (r_count == 3'd7) begin
          r_pad   <= '0;
          r_last  <= 1'b0;
          r_count <= '0;
          r_full  <= 1'b1;
        end else begin
          r_count <= r_count + 3'd1;
        end
      end else if (i_take) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_din_ready = w_ready;
  assign o_full      = r_full;
  assign o_pad       = r_pad;
  assign o_last      = r_last;
  assign o_data      = {r_bytes[0], r_bytes[1], r_bytes[2], r_bytes[3],
                        r_bytes[4], r_bytes[5], r_bytes[6], r_bytes[7]};

endmodule

// File: rtl/des_block_loader.sv
// Byte-stream to 64-bit block feeder for the DES initial permutation.
// The packer fills the next block while the hold register presents the current one.
module des_block_loader
  import des_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PAD_BYTE   = 8'h00,
  parameter int                BYTE_COUNT = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [BYTE_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  input  logic              DIN_LAST,
  output logic [BLOCK_W:1]  PLAIN_TEXT,
  output logic              CHIP_SELECT_BAR,
  output logic              BLOCK_LAST,
  input  logic              BLOCK_ACK,
  output logic [PAD_W-1:0]  PAD_COUNT
);

  hold_state_e       r_state;
  hold_state_e       w_next;
  logic              w_load;
  logic [BLOCK_W:1]  r_data;
  logic              r_last;
  logic [PAD_W-1:0]  r_pad;

  logic              w_full;
  logic [BLOCK_W:1]  w_fill_data;
  logic [PAD_W-1:0]  w_fill_pad;
  logic              w_fill_last;

  des_byte_packer #(
    .PAD_BYTE   (PAD_BYTE),
    .BYTE_COUNT (BYTE_COUNT)
  ) u_packer (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_din       (DIN),
    .i_din_valid (DIN_VALID),
    .i_din_last  (DIN_LAST),
    .i_take      (w_load),
    .o_din_ready (DIN_READY),
    .o_full      (w_full),
    .o_data      (w_fill_data),
    .o_pad       (w_fill_pad),
    .o_last      (w_fill_last)
  );

  // An ack arriving with a full fill buffer reloads in place, so chip select never blips high.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_full) begin
          w_next = PRESENT;
          w_load = 1'b1;
        end
      end
      PRESENT: begin
        if (BLOCK_ACK) begin
          if (w_full) begin
            w_load = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_pad   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_data <= w_fill_data;
        r_last <= w_fill_last;
        r_pad  <= w_fill_pad;
      end
    end
  end

  assign PLAIN_TEXT      = r_data;
  assign BLOCK_LAST      = r_last;
  assign PAD_COUNT       = r_pad;
  assign CHIP_SELECT_BAR = (r_state != PRESENT);

endmodule

// File: tb/tb_des_block_loader.sv
// Directed checks of the block loader followed by a randomized run scored
// against a message-level model of how bytes group into padded blocks.
module tb_des_block_loader;

  localparam int NUM_BLOCKS = 1000;
  localparam int CYCLE_CAP  = 60000;

  logic        CLK;
  logic        RESET;
  logic [7:0]  DIN;
  logic        DIN_VALID;
  logic        DIN_READY;
  logic        DIN_LAST;
  logic [64:1] PLAIN_TEXT;
  logic        CHIP_SELECT_BAR;
  logic        BLOCK_LAST;
  logic        BLOCK_ACK;
  logic [3:0]  PAD_COUNT;

  des_block_loader #(
    .PAD_BYTE   (8'h00),
    .BYTE_COUNT (8)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .DIN             (DIN),
    .DIN_VALID       (DIN_VALID),
    .DIN_READY       (DIN_READY),
    .DIN_LAST        (DIN_LAST),
    .PLAIN_TEXT      (PLAIN_TEXT),
    .CHIP_SELECT_BAR (CHIP_SELECT_BAR),
    .BLOCK_LAST      (BLOCK_LAST),
    .BLOCK_ACK       (BLOCK_ACK),
    .PAD_COUNT       (PAD_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [3:0]  pad;
  } expBlk_t;

  expBlk_t     expQ [$];
  logic [7:0]  curBytes [$];
  expBlk_t     expHead;
  bit          randomOn = 1'b0;
  logic        prevCsb;
  bit          prevAckTaken;
  logic [63:0] heldData;
  logic        heldLast;
  logic [3:0]  heldPad;
  int          generated;
  int          seen;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    else
      passCount++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Holds the byte until the loader takes it; leaves DIN_VALID high for streaming.
  task automatic applyStimulus(input logic [7:0] b, input logic last);
    bit done;
    done = 1'b0;
    DIN       = b;
    DIN_LAST  = last;
    DIN_VALID = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      if (DIN_READY) done = 1'b1;
      @(posedge CLK);
      #1;
    end
    if (!done) checkOutput("din_ready_wait", 64'(DIN_READY), 64'd1);
  endtask

  task automatic ackOnce();
    BLOCK_ACK = 1'b1;
    tick();
    BLOCK_ACK = 1'b0;
  endtask

  // Message-level model: bytes group into blocks of 8, a last byte closes and pads.
  task automatic modelByte(input logic [7:0] b, input logic last);
    expBlk_t blk;
    int n;
    curBytes.push_back(b);
    n = curBytes.size();
    if (last || n == 8) begin
      blk.data = '0;
      for (int k = 0; k < 8; k++)
        blk.data[63 - 8*k -: 8] = (k < n) ? curBytes[k] : 8'h00;
      blk.last = last;
      blk.pad  = 4'(8 - n);
      expQ.push_back(blk);
      curBytes.delete();
      generated++;
    end
  endtask

  always @(negedge CLK) begin
    if (randomOn) begin
      if (!CHIP_SELECT_BAR && (prevCsb || prevAckTaken)) begin
        checkOutput("rnd_block_expected", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) begin
          expHead = expQ.pop_front();
          checkOutput("rnd_data", PLAIN_TEXT, expHead.data);
          checkOutput("rnd_last", 64'(BLOCK_LAST), 64'(expHead.last));
          checkOutput("rnd_pad", 64'(PAD_COUNT), 64'(expHead.pad));
          seen++;
        end
      end else if (!CHIP_SELECT_BAR) begin
        checkOutput("rnd_stable_data", PLAIN_TEXT, heldData);
        checkOutput("rnd_stable_flags", 64'({BLOCK_LAST, PAD_COUNT}), 64'({heldLast, heldPad}));
      end
      heldData     = PLAIN_TEXT;
      heldLast     = BLOCK_LAST;
      heldPad      = PAD_COUNT;
      prevCsb      = CHIP_SELECT_BAR;
      prevAckTaken = BLOCK_ACK && !CHIP_SELECT_BAR;
      if (DIN_VALID && DIN_READY) modelByte(DIN, DIN_LAST);
    end
  end

  initial begin
    int cycles;
    RESET     = 1'b1;
    DIN       = 8'h00;
    DIN_VALID = 1'b0;
    DIN_LAST  = 1'b0;
    BLOCK_ACK = 1'b0;
    tick();

    // Reset state and arming of DIN_READY
    checkOutput("rst_csb", 64'(CHIP_SELECT_BAR), 64'd1);
    checkOutput("rst_pt", PLAIN_TEXT, 64'h0);
    checkOutput("rst_last", 64'(BLOCK_LAST), 64'd0);
    checkOutput("rst_pad", 64'(PAD_COUNT), 64'd0);
    checkOutput("rst_ready", 64'(DIN_READY), 64'd0);
    RESET = 1'b0;
    #1;
    checkOutput("ready_before_edge", 64'(DIN_READY), 64'd0);
    tick();
    checkOutput("ready_after_edge", 64'(DIN_READY), 64'd1);

    // Single block with ACK tied high
    BLOCK_ACK = 1'b1;
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 1'b0);
    DIN_VALID = 1'b0;
    checkOutput("t1_csb_not_yet", 64'(CHIP_SELECT_BAR), 64'd1);
    tick();
    checkOutput("t1_csb_low", 64'(CHIP_SELECT_BAR), 64'd0);
    checkOutput("t1_pt", PLAIN_TEXT, 64'h0102030405060708);
    checkOutput("t1_last", 64'(BLOCK_LAST), 64'd0);
    checkOutput("t1_pad", 64'(PAD_COUNT), 64'd0);
    tick();
    checkOutput("t1_csb_released", 64'(CHIP_SELECT_BAR), 64'd1);
    checkOutput("t1_pt_kept", PLAIN_TEXT, 64'h0102030405060708);
    BLOCK_ACK = 1'b0;

    // Two blocks back to back under backpressure
    for (int i = 1; i <= 16; i++) applyStimulus(8'(i), 1'b0);
    DIN_VALID = 1'b0;
    checkOutput("t2_csb_low", 64'(CHIP_SELECT_BAR), 64'd0);
    checkOutput("t2_blk1_held", PLAIN_TEXT, 64'h0102030405060708);
    checkOutput("t2_ready_low", 64'(DIN_READY), 64'd0);
    ackOnce();
    checkOutput("t2_csb_no_gap", 64'(CHIP_SELECT_BAR), 64'd0);
    checkOutput("t2_blk2", PLAIN_TEXT, 64'h090A0B0C0D0E0F10);
    checkOutput("t2_ready_back", 64'(DIN_READY), 64'd1);
    ackOnce();
    checkOutput("t2_csb_released", 64'(CHIP_SELECT_BAR), 64'd1);

    // Short message padded out
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b0);
    applyStimulus(8'hCC, 1'b1);
    DIN_VALID = 1'b0;
    DIN_LAST  = 1'b0;
    tick();
    checkOutput("t3_pt", PLAIN_TEXT, 64'hAABBCC0000000000);
    checkOutput("t3_pad", 64'(PAD_COUNT), 64'd5);
    checkOutput("t3_last", 64'(BLOCK_LAST), 64'd1);
    ackOnce();

    // Last on the first byte, then a stray ACK while idle
    applyStimulus(8'h5A, 1'b1);
    DIN_VALID = 1'b0;
    DIN_LAST  = 1'b0;
    tick();
    checkOutput("t4_pt", PLAIN_TEXT, 64'h5A00000000000000);
    checkOutput("t4_pad", 64'(PAD_COUNT), 64'd7);
    checkOutput("t4_last", 64'(BLOCK_LAST), 64'd1);
    ackOnce();
    checkOutput("t4_csb_idle", 64'(CHIP_SELECT_BAR), 64'd1);
    ackOnce();
    tick();
    checkOutput("t4_idle_ack_csb", 64'(CHIP_SELECT_BAR), 64'd1);
    checkOutput("t4_idle_ack_pt", PLAIN_TEXT, 64'h5A00000000000000);
    checkOutput("t4_idle_ack_ready", 64'(DIN_READY), 64'd1);

    // Asynchronous reset with a block presented and a partial fill
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'h21 + i), 1'b0);
    DIN_VALID = 1'b0;
    tick();
    checkOutput("t5_presented", 64'(CHIP_SELECT_BAR), 64'd0);
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h31 + i), 1'b0);
    DIN_VALID = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("t5_async_csb", 64'(CHIP_SELECT_BAR), 64'd1);
    checkOutput("t5_async_pt", PLAIN_TEXT, 64'h0);
    tick();
    RESET = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'h11 + i), 1'b0);
    DIN_VALID = 1'b0;
    tick();
    checkOutput("t5_csb", 64'(CHIP_SELECT_BAR), 64'd0);
    checkOutput("t5_pt", PLAIN_TEXT, 64'h1112131415161718);
    checkOutput("t5_pad", 64'(PAD_COUNT), 64'd0);
    ackOnce();

    // Randomized run against the model
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
    generated    = 0;
    seen         = 0;
    prevCsb      = 1'b1;
    prevAckTaken = 1'b0;
    heldData     = '0;
    heldLast     = 1'b0;
    heldPad      = '0;
    expQ.delete();
    curBytes.delete();
    randomOn = 1'b1;
    cycles   = 0;
    while (seen < NUM_BLOCKS && cycles < CYCLE_CAP) begin
      DIN_VALID = (generated < NUM_BLOCKS) && ($urandom_range(0, 9) < 7);
      DIN       = 8'($urandom);
      DIN_LAST  = ($urandom_range(0, 5) == 0);
      BLOCK_ACK = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    DIN_VALID = 1'b0;
    BLOCK_ACK = 1'b0;
    @(negedge CLK);
    randomOn = 1'b0;
    checkOutput("rnd_blocks_seen", 64'(seen), 64'(NUM_BLOCKS));
    checkOutput("rnd_queue_drained", 64'(expQ.size()), 64'd0);
    checkOutput("rnd_no_partial", 64'(curBytes.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
